// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared constants and types for the 4x4 matrix accelerator front end.
//   N        array dimension (weight rows per job, lanes per vector)
//   DW       activation / weight lane width
//   ACC_W    result lane width
//   RES_LAT  cycles from activation on acc_activation to its row on acc_result
//   CNT_W    width of num_vec and the job counters
// ---------------------------------------------------------------------------
package accel_pkg;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int ACC_W   = 24;
    localparam int RES_LAT = 7;
    localparam int CNT_W   = 16;

    localparam int ACT_W   = N * DW;
    localparam int RES_W   = N * ACC_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/valid_pipe.sv
// ---------------------------------------------------------------------------
// valid_pipe
// DEPTH-deep single-bit shift register that follows the accelerator latency,
// marking which result rows belong to real vectors and which are bubbles.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   din    in   1 = a real vector enters the array this cycle
//   dout   out  oldest bit; its result row is on acc_result this cycle
//   empty  out  no real vector in flight
// ---------------------------------------------------------------------------
module valid_pipe #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(din);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout  = pipe_q[DEPTH-1];
    assign empty = (pipe_q == '0);

endmodule

// File: rtl/accel_sequencer.sv
// ---------------------------------------------------------------------------
// accel_sequencer
// Front-end controller for the 4x4 matrix accelerator: loads N weight rows,
// streams num_vec activation vectors (inserting zero bubbles when the host is
// late, since the array cannot stall) and tags result rows as valid.
//
// Optional build macro: SEQ_PERF_CNT_EN adds stall_cycles / job_cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, num_vec      job request (sampled in IDLE only) and vector count
//   busy, done          job in progress, one-cycle end-of-job pulse
//   w_data/valid/ready  weight row stream
//   a_data/valid/ready  activation vector stream
//   acc_load_weight     accelerator load_weight
//   acc_activation      accelerator activation_in (weights during LOAD_W)
//   acc_result          accelerator result_out
//   res_data/res_valid  registered result row, no backpressure
//   stall_cycles        (SEQ_PERF_CNT_EN) COMPUTE cycles starved of input
//   job_cycles          (SEQ_PERF_CNT_EN) cycles with busy high
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_W  | accepting N weight rows into the array
// COMPUTE | feeding activation vectors, bubbles when none available
// DRAIN   | waiting for in-flight results to leave the array
// DONE    | one-cycle done pulse, busy drops on exit
// ---------------------------------------------------------------------------
module accel_sequencer
    import accel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
`ifdef SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] job_cycles,
`endif
    input  logic [ACT_W-1:0] w_data,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [ACT_W-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic             acc_load_weight,
    output logic [ACT_W-1:0] acc_activation,
    input  logic [RES_W-1:0] acc_result,
    output logic [RES_W-1:0] res_data,
    output logic             res_valid
);

    localparam int WCNT_W = $clog2(N + 1);

    seq_state_t       state_q,     state_d;
    logic             busy_q,      busy_d;
    logic [CNT_W-1:0] num_vec_q,   num_vec_d;
    logic [CNT_W-1:0] vcnt_q,      vcnt_d;
    logic [WCNT_W-1:0] wcnt_q,     wcnt_d;
    logic             res_valid_q, res_valid_d;
    logic [RES_W-1:0] res_data_q,  res_data_d;

    logic             w_acc;
    logic             a_rdy;
    logic             a_acc;
    logic [ACT_W-1:0] act;
    logic             pipe_out;
    logic             pipe_empty;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        num_vec_d   = num_vec_q;
        vcnt_d      = vcnt_q;
        wcnt_d      = wcnt_q;

        w_acc = (state_q == LOAD_W) && w_valid;
        a_rdy = (state_q == COMPUTE) && (vcnt_q < num_vec_q);
        a_acc = a_rdy && a_valid;

        // Anything not accepted this cycle becomes a zero bubble.
        if (w_acc) begin
            act = w_data;
        end else if (a_acc) begin
            act = a_data;
        end else begin
            act = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_vec_d = num_vec;
                    vcnt_d    = '0;
                    wcnt_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_acc) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(N - 1)) begin
                        state_d = (num_vec_q != '0) ? COMPUTE : DONE;
                    end
                end
            end
            COMPUTE: begin
                // a_rdy guarantees num_vec_q > vcnt_q, so the subtraction
                // cannot underflow and vcnt never wraps.
                if (a_acc) begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                    if (vcnt_q == num_vec_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty && !res_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        res_valid_d = pipe_out;
        res_data_d  = pipe_out ? acc_result : res_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            num_vec_q   <= '0;
            vcnt_q      <= '0;
            wcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            num_vec_q   <= num_vec_d;
            vcnt_q      <= vcnt_d;
            wcnt_q      <= wcnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    valid_pipe #(
        .DEPTH (RES_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .din   (a_acc),
        .dout  (pipe_out),
        .empty (pipe_empty)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] job_q,   job_d;

    always_comb begin
        stall_d = stall_q;
        job_d   = job_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
            job_d   = '0;
        end else begin
            if (busy_q && (job_q != '1)) begin
                job_d = job_q + CNT_W'(1);
            end
            if (a_rdy && !a_valid && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            job_q   <= '0;
        end else begin
            stall_q <= stall_d;
            job_q   <= job_d;
        end
    end

    assign stall_cycles = stall_q;
    assign job_cycles   = job_q;
`endif

    assign busy            = busy_q;
    assign done            = (state_q == DONE);
    assign w_ready         = (state_q == LOAD_W);
    assign a_ready         = a_rdy;
    assign acc_load_weight = w_acc;
    assign acc_activation  = act;
    assign res_data        = res_data_q;
    assign res_valid       = res_valid_q;

endmodule

// File: tb/tb_accel_sequencer.sv
module tb_accel_sequencer;
    import accel_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             busy;
    logic             done;
    logic [ACT_W-1:0] w_data = '0;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic [ACT_W-1:0] a_data = '0;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic             acc_load_weight;
    logic [ACT_W-1:0] acc_activation;
    logic [RES_W-1:0] acc_result;
    logic [RES_W-1:0] res_data;
    logic             res_valid;
`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] job_cycles;
`endif

    always #5 clk = ~clk;

    accel_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_vec         (num_vec),
        .busy            (busy),
        .done            (done),
`ifdef SEQ_PERF_CNT_EN
        .stall_cycles    (stall_cycles),
        .job_cycles      (job_cycles),
`endif
        .w_data          (w_data),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .a_data          (a_data),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .acc_load_weight (acc_load_weight),
        .acc_activation  (acc_activation),
        .acc_result      (acc_result),
        .res_data        (res_data),
        .res_valid       (res_valid)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int res_cnt  = 0;
    int load_cnt = 0;
    bit a_ready_seen = 1'b0;

    typedef struct {
        logic [RES_W-1:0] data;
        int               cyc;
    } exp_t;
    exp_t sb[$];

    logic [ACT_W-1:0] wt [N];

    function automatic logic [RES_W-1:0] matmul(input logic [ACT_W-1:0] v,
                                                input logic [ACT_W-1:0] w [N]);
        logic [RES_W-1:0] r;
        logic [ACC_W-1:0] s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = '0;
            for (int k = 0; k < N; k++) begin
                s = s + ACC_W'(v[8*k +: 8]) * ACC_W'(w[k][8*j +: 8]);
            end
            r[ACC_W*j +: ACC_W] = s;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accelerator model: weights latched on load_weight, fixed RES_LAT delay.
    logic [ACT_W-1:0] mw [N];
    int               widx;
    logic [RES_W-1:0] dl [RES_LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx <= 0;
            for (int i = 0; i < N; i++) mw[i] <= '0;
            for (int i = 0; i < RES_LAT; i++) dl[i] <= '0;
        end else begin
            if (acc_load_weight) begin
                mw[widx] <= acc_activation;
                widx     <= (widx + 1) % N;
            end
            dl[0] <= matmul(acc_activation, mw);
            for (int i = 1; i < RES_LAT; i++) dl[i] <= dl[i-1];
        end
    end
    assign acc_result = dl[RES_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_load_weight) load_cnt <= load_cnt + 1;
    end

    // Result monitor: every scoreboard entry carries its due cycle.
    always @(negedge clk) begin : mon
        bit due;
        if (rst) begin
            due = (sb.size() > 0) && (sb[0].cyc == cyc);
            if (res_valid || due) begin
                chk("res_valid_timing", res_valid, due);
                if (res_valid && due) begin
                    chk("res_data", res_data, sb[0].data);
                    void'(sb.pop_front());
                    res_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_during_done", busy, 1'b1);
            end
            if (a_ready) a_ready_seen = 1'b1;
        end
    end

    task automatic run_job(input int nv, input logic [31:0] avpat, input int wgap,
                           input bit start_in_drain);
        int d0, l0, k, vidx, t;
        logic [ACT_W-1:0] v;
        for (int r = 0; r < N; r++) wt[r] = $urandom;
        @(negedge clk);
        a_ready_seen = 1'b0;
        res_cnt = 0;
        d0 = done_cnt;
        l0 = load_cnt;
        start = 1'b1;
        num_vec = CNT_W'(nv);
        #1 chk("busy_before_start", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        num_vec = '0;
        #1 chk("busy_after_start", busy, 1'b1);
        chk("w_ready_load", w_ready, 1'b1);
        for (int r = 0; r < N; r++) begin
            if (r == 2) begin
                for (int g = 0; g < wgap; g++) begin
                    w_valid = 1'b0;
                    #1 chk("no_load_in_gap", acc_load_weight, 1'b0);
                    @(negedge clk);
                end
            end
            w_valid = 1'b1;
            w_data  = wt[r];
            #1 chk("load_weight", acc_load_weight, 1'b1);
            chk("weight_to_array", acc_activation, wt[r]);
            @(negedge clk);
        end
        w_valid = 1'b0;
        w_data  = '0;
        k = 0;
        vidx = 0;
        while (vidx < nv && k < 200) begin
            a_valid = (k < 32) ? avpat[k] : 1'b1;
            v = $urandom;
            a_data = v;
            #1 chk("a_ready_compute", a_ready, 1'b1);
            if (a_ready && a_valid) begin
                chk("act_to_array", acc_activation, v);
                sb.push_back(exp_t'{matmul(v, wt), cyc + RES_LAT + 1});
                vidx++;
            end else begin
                chk("bubble_zero", acc_activation, '0);
            end
            @(negedge clk);
            k++;
        end
        a_valid = 1'b0;
        a_data  = '0;
        #1 chk("a_ready_after_compute", a_ready, 1'b0);
        chk("act_zero_after_compute", acc_activation, '0);
        chk("rows_loaded", load_cnt - l0, N);
        if (start_in_drain) begin
            start = 1'b1;
            num_vec = CNT_W'(9);
            @(negedge clk);
            start = 1'b0;
            num_vec = '0;
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1 chk("done_pulses", done_cnt - d0, 1);
        chk("busy_after_done", busy, 1'b0);
        chk("results_count", res_cnt, nv);
        chk("scoreboard_empty", sb.size(), 0);
        if (nv == 0) chk("a_ready_never", a_ready_seen, 1'b0);
    endtask

    initial begin
        int d0, rc0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_load_weight", acc_load_weight, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_activation", acc_activation, '0);
        chk("rst_res_data", res_data, '0);
        @(negedge clk);
        rst = 1'b1;

        // basic job, back-to-back vectors
        run_job(3, 32'hFFFF_FFFF, 0, 1'b0);

        // a_valid pattern 1,0,0,1,1
        run_job(3, 32'hFFFF_FFF9, 0, 1'b0);
`ifdef SEQ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 2);
        chk("job_cycles", job_cycles, 19);
`endif

        // weight stream stalls 5 cycles between rows 2 and 3
        run_job(3, 32'hFFFF_FFFF, 5, 1'b0);

        // zero-length job
        run_job(0, 32'hFFFF_FFFF, 0, 1'b0);

        // reset after 2 of 5 vectors
        for (int r = 0; r < N; r++) wt[r] = $urandom;
        @(negedge clk);
        d0 = done_cnt;
        rc0 = res_cnt;
        start = 1'b1;
        num_vec = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        num_vec = '0;
        for (int r = 0; r < N; r++) begin
            w_valid = 1'b1;
            w_data = wt[r];
            @(negedge clk);
        end
        w_valid = 1'b0;
        w_data = '0;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1;
            a_data = $urandom;
            @(negedge clk);
        end
        a_valid = 1'b1;
        a_data = $urandom;
        #1 rst = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_w_ready", w_ready, 1'b0);
        chk("abort_a_ready", a_ready, 1'b0);
        chk("abort_load_weight", acc_load_weight, 1'b0);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_activation", acc_activation, '0);
        chk("abort_res_data", res_data, '0);
        a_valid = 1'b0;
        a_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        #1 chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_results", res_cnt - rc0, 0);
        run_job(2, 32'hFFFF_FFFF, 0, 1'b0);

        // start pulsed during DRAIN must be ignored
        run_job(3, 32'hFFFF_FFFF, 0, 1'b1);
        repeat (5) @(negedge clk);
        #1 chk("busy_stays_low", busy, 1'b0);
        chk("w_ready_stays_low", w_ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/accel_sequencer.md
Name: accel_sequencer

Overview:
- Front-end controller for the 4x4 matrix accelerator.
- On a start command it:
  - streams N weight rows into the array with load_weight asserted;
  - streams num_vec activation vectors through the skew path;
  - tags each result row emerging RES_LAT cycles later as valid.
- Sits between the host-side streaming interfaces and the accelerator. The accelerator cannot stall, so the sequencer inserts zero bubbles when activations are late and tracks validity itself.

Parameters:
- N, 4, array dimension (weight rows to load, lanes per vector)
- DW, 8, activation/weight lane width; bus width N*DW = 32
- ACC_W, 24, result lane width; result bus N*ACC_W = 96
- RES_LAT, 7, cycles from activation presented on acc_activation to its result row on acc_result
- CNT_W, 16, width of num_vec and counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  begin a job; sampled in IDLE only
- num_vec  in  CNT_W  activation vectors in job; captured with start
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at job end
- w_data  in  32  weight row
- w_valid  in  1  weight row valid
- w_ready  out  1  high in LOAD_W only
- a_data  in  32  activation vector
- a_valid  in  1  activation valid
- a_ready  out  1  high in COMPUTE while vectors remain
- acc_load_weight  out  1  to accelerator load_weight
- acc_activation  out  32  to accelerator activation_in
- acc_result  in  96  from accelerator result_out
- res_data  out  96  registered result row
- res_valid  out  1  res_data holds a real result; no backpressure

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; busy, done, w_ready, a_ready, acc_load_weight, res_valid = 0.
  - acc_activation and res_data = 0; all counters and the valid pipe = 0.
- Reset mid-job aborts immediately; no done pulse is produced.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 captures num_vec, clears counters, sets busy=1, goes to LOAD_W.
  - start outside IDLE is ignored.
- LOAD_W:
  - w_ready=1.
  - On w_valid&w_ready, in the same cycle (combinational): acc_activation=w_data, acc_load_weight=1, and wcnt increments.
  - Otherwise acc_load_weight=0 and acc_activation=0.
  - After N accepted rows: go to COMPUTE if num_vec>0, else DONE.
- COMPUTE:
  - a_ready=1 while vcnt<num_vec.
  - Accept (a_valid&a_ready): acc_activation=a_data, vcnt++, push 1 into valid pipe.
  - No accept: acc_activation=0 (bubble), push 0.
  - acc_load_weight=0 throughout.
  - When vcnt reaches num_vec after an accept, go to DRAIN.
- Valid pipe:
  - RES_LAT-deep shift register that shifts every cycle in every state.
  - Output bit is registered together with acc_result into res_valid/res_data.
  - A vector accepted in cycle t yields res_valid=1 at cycle t+RES_LAT+1.
  - res_data updates only when the pipe output bit is 1; otherwise it holds.
- DRAIN:
  - acc_activation=0, a_ready=0.
  - When the valid pipe and the res_valid stage are both empty, go to DONE.
- DONE:
  - done=1 for one cycle, busy=0 on exit, then go to IDLE.
  - A start in this cycle is ignored.
- Ordering: results appear in vector-acceptance order, exactly num_vec res_valid pulses per job.
- num_vec=0xFFFF is legal; vcnt is CNT_W wide and never wraps.

Optional Feature:
- SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[CNT_W] and job_cycles[CNT_W].
  - Both clear on an accepted start.
  - stall_cycles counts COMPUTE cycles with a_ready&!a_valid; job_cycles counts cycles with busy=1.
  - Both saturate at all-ones and hold after done until the next start.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package accel_pkg:
  - constants N, DW, ACC_W, RES_LAT, CNT_W;
  - derived ACT_W=N*DW, RES_W=N*ACC_W;
  - state enum seq_state_t {IDLE, LOAD_W, COMPUTE, DRAIN, DONE}.
- Sub-module valid_pipe: parameterised DEPTH shift register with async active-low reset, plus an empty flag. Used for bubble tracking and the DRAIN exit condition.

Test Plan:
- Basic job: start, num_vec=3, weights fed back-to-back.
  - acc_load_weight high exactly 4 cycles.
  - 3 res_valid pulses starting 8 cycles after the first accept.
  - done pulse after the last result; busy low afterwards.
- Bubbles: a_valid pattern 1,0,0,1,1 for num_vec=3.
  - res_valid pattern mirrors it with gaps 1,0,0,1,1.
  - res_data matches the golden matmul per vector.
  - With SEQ_PERF_CNT_EN: stall_cycles=2.
- Weight stall: w_valid low 5 cycles between rows 2 and 3.
  - acc_load_weight low during the gap.
  - The array still receives exactly 4 rows; results are correct.
- Zero-length job: num_vec=0.
  - After 4 weight rows, go directly to DONE.
  - No res_valid pulses; a_ready never asserted.
- Reset mid-COMPUTE: rst=0 after 2 of 5 vectors.
  - All outputs are 0 immediately, state is IDLE, no done pulse.
  - A following job with num_vec=2 completes correctly.
- Start while busy: pulse start during DRAIN with num_vec=9.
  - It is ignored; the job finishes with its original count.
  - busy stays 0 after DONE until a new start.
